// File: rtl/tx_pam_ffe.sv
// PRBS-driven NRZ/PAM4 transmitter with a 3-tap FFE and sample-held real output.
// Ports: clk, rst (sync, active-high), en, load_seed, seed[30:0] in;
//        tx_out (real), sym_out[1:0], sym_valid, ui_strobe out.
// Optional: define TX_ERR_INJECT_EN to add the inject_err input, which
//           inverts one bit of the next generated symbol.
module tx_pam_ffe #(
    parameter int  PRBS_ORDER     = 7,
    parameter int  PAM_LEVELS     = 2,
    parameter int  SAMPLES_PER_UI = 16,
    parameter real C_PRE          = 0.0,
    parameter real C_MAIN         = 1.0,
    parameter real C_POST1        = 0.0,
    parameter real AMP            = 1.0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_seed,
    input  logic [30:0] seed,
`ifdef TX_ERR_INJECT_EN
    input  logic        inject_err,
`endif
    output real         tx_out,
    output logic [1:0]  sym_out,
    output logic        sym_valid,
    output logic        ui_strobe
);

    localparam int CNT_W = (SAMPLES_PER_UI > 1) ?
                           $clog2(SAMPLES_PER_UI) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_UI - 1);
    localparam bit IS_PAM4 = (PAM_LEVELS == 4);
    localparam int TAP_A = PRBS_ORDER - 1;
    localparam int TAP_B = (PRBS_ORDER == 31) ? 27 : PRBS_ORDER - 2;
    localparam logic [30:0] MASK = 31'((64'd1 << PRBS_ORDER) - 64'd1);

    logic [CNT_W-1:0] samp_cnt;
    logic [30:0]      lfsr;
    logic [30:0]      lfsr_1;
    logic [30:0]      lfsr_2;
    logic [30:0]      lfsr_adv;
    logic [30:0]      seed_m;
    logic [30:0]      seed_fix;
    logic             fb0;
    logic             fb1;
    logic [1:0]       pair;
    logic [1:0]       new_idx;
    real              new_lvl;
    real              ffe_sum;
    real              h_next;
    real              h_cur;
    real              h_prev;
    logic             out_pend;
    logic             boundary;
    logic             flip;

    // The state is always held in 31 bits; bits above PRBS_ORDER stay zero.
    function automatic logic [30:0] lfsr_step(input logic [30:0] s);
        return ((s << 1) | {30'd0, s[TAP_A] ^ s[TAP_B]}) & MASK;
    endfunction

    assign boundary = en && !load_seed && (samp_cnt == CNT_LAST);
    assign seed_m   = seed & MASK;
    assign seed_fix = (seed_m == 31'd0) ? MASK : seed_m;

`ifdef TX_ERR_INJECT_EN
    logic err_pend;

    // A pulse arriving on the boundary cycle is applied there directly.
    assign flip = err_pend | inject_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend <= 1'b0;
        end else if (boundary) begin
            err_pend <= 1'b0;
        end else if (inject_err) begin
            err_pend <= 1'b1;
        end
    end
`else
    assign flip = 1'b0;
`endif

    always_comb begin
        fb0     = lfsr[TAP_A] ^ lfsr[TAP_B];
        lfsr_1  = lfsr_step(lfsr);
        fb1     = lfsr_1[TAP_A] ^ lfsr_1[TAP_B];
        lfsr_2  = lfsr_step(lfsr_1);
        pair    = 2'b00;
        new_idx = 2'd0;
        new_lvl = 0.0;
        if (IS_PAM4) begin
            // First bit is the MSB; injected errors hit the LSB only.
            pair    = {fb0, fb1 ^ flip};
            new_idx = {pair[1], pair[1] ^ pair[0]};
            unique case (new_idx)
                2'd0: new_lvl = -1.0;
                2'd1: new_lvl = -1.0 / 3.0;
                2'd2: new_lvl = 1.0 / 3.0;
                2'd3: new_lvl = 1.0;
            endcase
        end else begin
            new_idx = {1'b0, fb0 ^ flip};
            new_lvl = new_idx[0] ? 1.0 : -1.0;
        end
    end

    assign lfsr_adv = IS_PAM4 ? lfsr_2 : lfsr_1;

    // Evaluated from the history registers, i.e. one clock after the shift.
    assign ffe_sum = AMP * (C_PRE * h_next + C_MAIN * h_cur
                            + C_POST1 * h_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= MASK;
            samp_cnt  <= '0;
            h_next    <= 0.0;
            h_cur     <= 0.0;
            h_prev    <= 0.0;
            tx_out    <= 0.0;
            sym_out   <= 2'd0;
            sym_valid <= 1'b0;
            ui_strobe <= 1'b0;
            out_pend  <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            ui_strobe <= 1'b0;
            if (load_seed) begin
                lfsr     <= seed_fix;
                samp_cnt <= '0;
            end else if (en) begin
                if (boundary) begin
                    samp_cnt  <= '0;
                    lfsr      <= lfsr_adv;
                    h_prev    <= h_cur;
                    h_cur     <= h_next;
                    h_next    <= new_lvl;
                    sym_out   <= new_idx;
                    sym_valid <= 1'b1;
                end else begin
                    samp_cnt <= samp_cnt + CNT_W'(1);
                end
                // Output update waits for the next enabled cycle.
                if (out_pend) begin
                    tx_out    <= ffe_sum;
                    ui_strobe <= 1'b1;
                end
                out_pend <= boundary;
            end
        end
    end

endmodule

// File: tb/tb_tx_pam_ffe.sv
// Self-checking bench for tx_pam_ffe: NRZ default, NRZ with post-cursor,
// and PAM4 instances checked against a bit-stream reference model.
module tb_tx_pam_ffe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        load_seed;
    logic [30:0] seed;
`ifdef TX_ERR_INJECT_EN
    logic        inject_err;
`endif

    real        a_tx, b_tx, c_tx;
    logic [1:0] a_sym, b_sym, c_sym;
    logic       a_vld, b_vld, c_vld;
    logic       a_stb, b_stb, c_stb;

    int errors = 0;
    int checks = 0;

    bit  gbits[$];
    int  gsym[$];
    real glev[$];
    int  osym[$];
    real otx[$];

    tx_pam_ffe u_a (
        .clk(clk), .rst(rst), .en(en), .load_seed(load_seed), .seed(seed),
`ifdef TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .tx_out(a_tx), .sym_out(a_sym), .sym_valid(a_vld), .ui_strobe(a_stb)
    );

    tx_pam_ffe #(.SAMPLES_PER_UI(4), .C_POST1(-0.25)) u_b (
        .clk(clk), .rst(rst), .en(en), .load_seed(load_seed), .seed(seed),
`ifdef TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .tx_out(b_tx), .sym_out(b_sym), .sym_valid(b_vld), .ui_strobe(b_stb)
    );

    tx_pam_ffe #(.PAM_LEVELS(4), .SAMPLES_PER_UI(4)) u_c (
        .clk(clk), .rst(rst), .en(en), .load_seed(load_seed), .seed(seed),
`ifdef TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .tx_out(c_tx), .sym_out(c_sym), .sym_valid(c_vld), .ui_strobe(c_stb)
    );

    function automatic bit rdiff(input real x, input real y);
        return (x - y > 1e-9) || (y - x > 1e-9);
    endfunction

    // PRBS7 as a bit recurrence: b[n] = b[n-7] ^ b[n-6], where the seed
    // bit k stands for the bit emitted k+1 steps before the first one.
    function automatic void gen_bits(input logic [6:0] s_in, input int n);
        bit w[$];
        logic [6:0] s;
        bit b;
        s = s_in;
        if (s == 7'd0) s = 7'h7f;
        gbits.delete();
        for (int k = 0; k < 7; k++) w.push_back(s[k]);
        for (int i = 0; i < n; i++) begin
            b = w[6] ^ w[5];
            gbits.push_back(b);
            w.push_front(b);
            void'(w.pop_back());
        end
    endfunction

    function automatic int gray(input bit m, input bit l);
        case ({m, l})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void build_model(input logic [6:0] s, input bit pam4,
                                        input int n);
        int v;
        gen_bits(s, pam4 ? 2 * n : n);
        gsym.delete();
        glev.delete();
        for (int i = 0; i < n; i++) begin
            if (pam4) begin
                v = gray(gbits[2*i], gbits[2*i+1]);
                glev.push_back((2.0 * v - 3.0) / 3.0);
            end else begin
                v = int'(gbits[i]);
                glev.push_back(v != 0 ? 1.0 : -1.0);
            end
            gsym.push_back(v);
        end
    endfunction

    function automatic real lev(input int k);
        if (k < 0 || k >= glev.size()) return 0.0;
        return glev[k];
    endfunction

    function automatic real exp_tx(input int j, input real pre,
                                   input real mn, input real post);
        return pre * lev(j) + mn * lev(j - 1) + post * lev(j - 2);
    endfunction

    function automatic logic get_vld(input int d);
        case (d)
            0:       return a_vld;
            1:       return b_vld;
            default: return c_vld;
        endcase
    endfunction

    function automatic logic get_stb(input int d);
        case (d)
            0:       return a_stb;
            1:       return b_stb;
            default: return c_stb;
        endcase
    endfunction

    function automatic int get_sym(input int d);
        case (d)
            0:       return int'(a_sym);
            1:       return int'(b_sym);
            default: return int'(c_sym);
        endcase
    endfunction

    function automatic real get_tx(input int d);
        case (d)
            0:       return a_tx;
            1:       return b_tx;
            default: return c_tx;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b1;
        load_seed = 1'b0;
        seed      = 31'd0;
`ifdef TX_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [30:0] s);
        seed      = s;
        load_seed = 1'b1;
        tick();
        load_seed = 1'b0;
    endtask

    task automatic collect(input int d, input int n);
        int guard;
        osym.delete();
        otx.delete();
        guard = 0;
        while (otx.size() < n && guard < n * 40 + 64) begin
            tick();
            guard++;
            if (get_vld(d)) osym.push_back(get_sym(d));
            if (get_stb(d)) otx.push_back(get_tx(d));
        end
        checks++;
        if (otx.size() < n) begin
            errors++;
            $display("FAIL collect dut=%0d strobes=%0d need=%0d",
                     d, otx.size(), n);
        end
    endtask

    task automatic test_reset();
        int first_stb;
        int nz;
        int vq[$];
        int sq[$];
        real tq[$];
        rst       = 1'b1;
        en        = 1'b1;
        load_seed = 1'b1;
        seed      = 31'h55;
`ifdef TX_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        repeat (3) tick();
        checks++;
        if (a_tx != 0.0 || a_sym !== 2'd0 || a_vld !== 1'b0 ||
            a_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_state tx=%f sym=%0d vld=%b stb=%b need 0",
                     a_tx, a_sym, a_vld, a_stb);
        end
        rst       = 1'b0;
        load_seed = 1'b0;
        first_stb = -1;
        nz        = 0;
        build_model(7'h7f, 1'b0, 3);
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (a_stb && first_stb < 0) first_stb = c;
            if (first_stb < 0 && a_tx != 0.0) nz++;
            if (a_vld) begin
                vq.push_back(c);
                sq.push_back(int'(a_sym));
            end
            if (a_stb) tq.push_back(a_tx);
        end
        checks++;
        if (first_stb != 17) begin
            errors++;
            $display("FAIL first_strobe got=%0d need=17", first_stb);
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL pre_strobe_tx nonzero_cycles=%0d need=0", nz);
        end
        checks++;
        if (vq.size() != 3 || vq[0] != 16 || vq[1] != 32 || vq[2] != 48) begin
            errors++;
            $display("FAIL vld_spacing count=%0d need 16,32,48", vq.size());
        end
        for (int i = 0; i < 3 && i < sq.size(); i++) begin
            checks++;
            if (sq[i] != gsym[i]) begin
                errors++;
                $display("FAIL reset_sym[%0d] got=%0d need=%0d",
                         i, sq[i], gsym[i]);
            end
        end
        for (int j = 0; j < 3 && j < tq.size(); j++) begin
            checks++;
            if (rdiff(tq[j], exp_tx(j, 0.0, 1.0, 0.0))) begin
                errors++;
                $display("FAIL reset_tx[%0d] got=%f need=%f",
                         j, tq[j], exp_tx(j, 0.0, 1.0, 0.0));
            end
        end
    endtask

    task automatic test_prbs_nrz();
        int first7[7] = '{0, 0, 0, 0, 0, 0, 1};
        int bad;
        logic [30:0] rs;
        do_reset();
        load(31'h7fffffff);
        collect(0, 140);
        build_model(7'h7f, 1'b0, 140);
        for (int i = 0; i < 7 && i < osym.size(); i++) begin
            checks++;
            if (osym[i] != first7[i]) begin
                errors++;
                $display("FAIL prbs_first7[%0d] got=%0d need=%0d",
                         i, osym[i], first7[i]);
            end
        end
        bad = 0;
        for (int i = 0; i < osym.size(); i++)
            if (osym[i] != gsym[i]) bad++;
        checks++;
        if (bad != 0 || osym.size() != 140) begin
            errors++;
            $display("FAIL prbs_seq diffs=%0d len=%0d need 0/140",
                     bad, osym.size());
        end
        bad = 0;
        for (int i = 0; i + 127 < osym.size(); i++)
            if (osym[i+127] != osym[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL prbs_period127 diffs=%0d need=0", bad);
        end
        bad = 0;
        for (int j = 0; j < otx.size(); j++)
            if (rdiff(otx[j], exp_tx(j, 0.0, 1.0, 0.0))) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL prbs_tx diffs=%0d need=0", bad);
        end
        rs = 31'($urandom);
        do_reset();
        load(rs);
        collect(0, 20);
        build_model(rs[6:0], 1'b0, 20);
        for (int i = 0; i < 20 && i < osym.size(); i++) begin
            checks++;
            if (osym[i] != gsym[i]) begin
                errors++;
                $display("FAIL rand_seed_sym[%0d] seed=%h got=%0d need=%0d",
                         i, rs, osym[i], gsym[i]);
            end
        end
    endtask

    task automatic test_ffe();
        logic [30:0] rs;
        do_reset();
        load(31'h7fffffff);
        collect(1, 20);
        build_model(7'h7f, 1'b0, 20);
        checks++;
        if (rdiff(otx[3], -0.75)) begin
            errors++;
            $display("FAIL ffe_settle got=%f need=-0.75", otx[3]);
        end
        checks++;
        if (rdiff(otx[7], 1.25)) begin
            errors++;
            $display("FAIL ffe_step got=%f need=1.25", otx[7]);
        end
        for (int j = 0; j < otx.size(); j++) begin
            checks++;
            if (rdiff(otx[j], exp_tx(j, 0.0, 1.0, -0.25))) begin
                errors++;
                $display("FAIL ffe_tx[%0d] got=%f need=%f",
                         j, otx[j], exp_tx(j, 0.0, 1.0, -0.25));
            end
        end
        rs = 31'($urandom);
        do_reset();
        load(rs);
        collect(1, 24);
        build_model(rs[6:0], 1'b0, 24);
        for (int j = 0; j < otx.size(); j++) begin
            checks++;
            if (rdiff(otx[j], exp_tx(j, 0.0, 1.0, -0.25))) begin
                errors++;
                $display("FAIL ffe_rand_tx[%0d] seed=%h got=%f need=%f",
                         j, rs, otx[j], exp_tx(j, 0.0, 1.0, -0.25));
            end
        end
    endtask

    task automatic test_pam4();
        bit pat[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        int  esym[4] = '{0, 1, 2, 3};
        real etx[4];
        int found;
        bit ok;
        logic [30:0] rs;
        etx[0] = -1.0;
        etx[1] = -1.0 / 3.0;
        etx[2] = 1.0 / 3.0;
        etx[3] = 1.0;
        found = -1;
        for (int s = 1; s < 128 && found < 0; s++) begin
            gen_bits(7'(s), 8);
            ok = 1'b1;
            for (int k = 0; k < 8; k++)
                if (gbits[k] != pat[k]) ok = 1'b0;
            if (ok) found = s;
        end
        do_reset();
        load(31'(found));
        collect(2, 12);
        build_model(7'(found), 1'b1, 12);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (osym[i] != esym[i]) begin
                errors++;
                $display("FAIL pam4_sym[%0d] got=%0d need=%0d",
                         i, osym[i], esym[i]);
            end
            checks++;
            if (rdiff(otx[i+1], etx[i])) begin
                errors++;
                $display("FAIL pam4_tx[%0d] got=%f need=%f",
                         i, otx[i+1], etx[i]);
            end
        end
        rs = 31'($urandom);
        do_reset();
        load(rs);
        collect(2, 20);
        build_model(rs[6:0], 1'b1, 20);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (osym[i] != gsym[i] ||
                rdiff(otx[i], exp_tx(i, 0.0, 1.0, 0.0))) begin
                errors++;
                $display("FAIL pam4_rand[%0d] seed=%h sym=%0d/%0d tx=%f/%f",
                         i, rs, osym[i], gsym[i], otx[i],
                         exp_tx(i, 0.0, 1.0, 0.0));
            end
        end
    endtask

    task automatic test_zero_seed_en();
        int  bad;
        int  wait_c;
        int  vsym;
        real hold;
        do_reset();
        load(31'h7fffff80);
        collect(0, 14);
        build_model(7'h7f, 1'b0, 16);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (osym[i] != gsym[i]) begin
                errors++;
                $display("FAIL zero_seed_sym[%0d] got=%0d need=%0d",
                         i, osym[i], gsym[i]);
            end
        end
        repeat (3) tick();
        hold = a_tx;
        en   = 1'b0;
        bad  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_stb || a_vld || rdiff(a_tx, hold)) bad++;
        end
        en     = 1'b1;
        wait_c = -1;
        vsym   = -1;
        for (int c = 1; c <= 40 && wait_c < 0; c++) begin
            tick();
            if (a_vld) vsym = int'(a_sym);
            if (a_stb) wait_c = c;
            else if (rdiff(a_tx, hold)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_hold bad_cycles=%0d need=0", bad);
        end
        checks++;
        if (wait_c != 13) begin
            errors++;
            $display("FAIL en_delay got=%0d need=13", wait_c);
        end
        checks++;
        if (vsym != gsym[14]) begin
            errors++;
            $display("FAIL en_resume_sym got=%0d need=%0d", vsym, gsym[14]);
        end
        checks++;
        if (rdiff(a_tx, exp_tx(14, 0.0, 1.0, 0.0))) begin
            errors++;
            $display("FAIL en_resume_tx got=%f need=%f",
                     a_tx, exp_tx(14, 0.0, 1.0, 0.0));
        end
        repeat (4) tick();
        hold = a_tx;
        load(31'h7fffffff);
        checks++;
        if (a_vld || a_stb || rdiff(a_tx, hold)) begin
            errors++;
            $display("FAIL load_keep vld=%b stb=%b tx=%f need 0/0/%f",
                     a_vld, a_stb, a_tx, hold);
        end
        wait_c = -1;
        for (int c = 1; c <= 40 && wait_c < 0; c++) begin
            tick();
            if (a_vld) begin
                wait_c = c;
                vsym   = int'(a_sym);
            end
        end
        checks++;
        if (wait_c != 16 || vsym != gsym[0]) begin
            errors++;
            $display("FAIL load_restart cycles=%0d sym=%0d need 16/%0d",
                     wait_c, vsym, gsym[0]);
        end
    endtask

`ifdef TX_ERR_INJECT_EN
    task automatic test_inject();
        int diffs;
        int where;
        do_reset();
        load(31'h7fffffff);
        repeat (5) tick();
        inject_err = 1'b1;
        tick();
        inject_err = 1'b0;
        collect(0, 20);
        build_model(7'h7f, 1'b0, 20);
        diffs = 0;
        where = -1;
        for (int i = 0; i < osym.size(); i++)
            if (osym[i] != gsym[i]) begin
                diffs++;
                if (where < 0) where = i;
            end
        checks++;
        if (diffs != 1 || where != 0) begin
            errors++;
            $display("FAIL inject diffs=%0d at=%0d need 1 at 0", diffs, where);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_prbs_nrz();
        test_ffe();
        test_pam4();
        test_zero_seed_en();
`ifdef TX_ERR_INJECT_EN
        test_inject();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
